// File: rtl/uart_arb.sv
// Two-requester packet arbiter feeding the UART TX; packets are discarded when no host terminal is present.
// Grant latency 1 cycle, data pass-through 0 cycles; the owner stalls on uart_rdy_i, dropped packets never stall.
module uart_arb #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       srst_i,
  input  logic       r0_val_i,
  input  logic [7:0] r0_data_i,
  input  logic       r0_last_i,
  output logic       r0_rdy_o,
  input  logic       r1_val_i,
  input  logic [7:0] r1_data_i,
  input  logic       r1_last_i,
  output logic       r1_rdy_o,
  output logic       uart_val_o,
  output logic [7:0] uart_data_o,
  input  logic       uart_rdy_i,
  input  logic       uart_avail_i,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {IDLE, GNT0, GNT1, DROP0, DROP1} state_e;

  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic       own;
  logic       fwd;
  logic       own_val;
  logic       own_last;
  logic [7:0] own_data;
  logic       own_rdy;
  logic       pick1;
  logic       acc;

  assign own      = (state_q == GNT1) || (state_q == DROP1);
  assign fwd      = (state_q == GNT0) || (state_q == GNT1);
  assign own_val  = own ? r1_val_i  : r0_val_i;
  assign own_last = own ? r1_last_i : r0_last_i;
  assign own_data = own ? r1_data_i : r0_data_i;
  // A dropping owner is always drained; a transmitting owner follows the UART.
  assign own_rdy  = fwd ? uart_rdy_i : 1'b1;
  assign acc      = (state_q != IDLE) && own_val && own_rdy;
  // On a tie, hand the grant to whoever did not own it last.
  assign pick1    = r1_val_i & (~r0_val_i | ~last_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    r0_rdy_o    = 1'b0;
    r1_rdy_o    = 1'b0;
    uart_val_o  = 1'b0;
    uart_data_o = 8'h00;
    grant_o     = 2'b00;
    timeout_o   = 1'b0;

    if (state_q == IDLE) begin
      if (r0_val_i || r1_val_i) begin
        cnt_d = '0;
        if (uart_avail_i) state_d = pick1 ? GNT1 : GNT0;
        else              state_d = pick1 ? DROP1 : DROP0;
      end
    end else begin
      grant_o     = own ? 2'b10 : 2'b01;
      r0_rdy_o    = ~own & own_rdy;
      r1_rdy_o    = own & own_rdy;
      uart_val_o  = fwd & own_val;
      uart_data_o = (fwd && own_val) ? own_data : 8'h00;

      if (acc) begin
        cnt_d = '0;
        if (own_last) begin
          state_d = IDLE;
          last_d  = own;
        end
      end else if (!own_val) begin
        if (cnt_q == CNT_MAX) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
          last_d    = own;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Host vanished mid-packet: keep draining the owner but stop transmitting.
      if (fwd && !uart_avail_i && state_d != IDLE) state_d = own ? DROP1 : DROP0;
    end

    if (srst_i) begin
      r0_rdy_o    = 1'b0;
      r1_rdy_o    = 1'b0;
      uart_val_o  = 1'b0;
      uart_data_o = 8'h00;
      grant_o     = 2'b00;
      timeout_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else if (srst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_arb.sv
// Bench for uart_arb: directed packet scenarios, a per-cycle reference model and literal sequence checks.
module tb_uart_arb;

  localparam int TO = 4;
  typedef logic [7:0] bq_t[$];

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       srst_i = 1'b0;
  logic       r0_val_i = 1'b0;
  logic [7:0] r0_data_i = 8'h00;
  logic       r0_last_i = 1'b0;
  logic       r1_val_i = 1'b0;
  logic [7:0] r1_data_i = 8'h00;
  logic       r1_last_i = 1'b0;
  logic       uart_rdy_i = 1'b1;
  logic       uart_avail_i = 1'b1;
  logic       r0_rdy_o;
  logic       r1_rdy_o;
  logic       uart_val_o;
  logic [7:0] uart_data_o;
  logic [1:0] grant_o;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  uart_arb #(.TIMEOUT(TO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .srst_i       (srst_i),
    .r0_val_i     (r0_val_i),
    .r0_data_i    (r0_data_i),
    .r0_last_i    (r0_last_i),
    .r0_rdy_o     (r0_rdy_o),
    .r1_val_i     (r1_val_i),
    .r1_data_i    (r1_data_i),
    .r1_last_i    (r1_last_i),
    .r1_rdy_o     (r1_rdy_o),
    .uart_val_o   (uart_val_o),
    .uart_data_o  (uart_data_o),
    .uart_rdy_i   (uart_rdy_i),
    .uart_avail_i (uart_avail_i),
    .grant_o      (grant_o),
    .timeout_o    (timeout_o)
  );

  // Requester byte queues: {last, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic acc0 = 1'b0;
  logic acc1 = 1'b0;

  // Per-cycle history sampled at the falling edge
  bq_t gnt_h, to_h, uv_h, r0r_h, r0a_h, tx_log;

  // Reference model: who owns the link, whether it is discarding, quiet-cycle count, previous owner
  int m_owner = -1;
  bit m_drop  = 1'b0;
  int m_quiet = 0;
  int m_prev  = 1;
  int nx_owner = -1;
  bit nx_drop  = 1'b0;
  int nx_quiet = 0;
  int nx_prev  = 1;

  function automatic string fmt(bq_t q, int b);
    string s = "";
    for (int i = b; i < q.size(); i++) s = {s, $sformatf("%h ", q[i])};
    return s;
  endfunction

  function automatic int sum(bq_t q, int b);
    int s = 0;
    for (int i = b; i < q.size(); i++) s += int'(q[i]);
    return s;
  endfunction

  task automatic chk_val(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic chk_seq(string name, bq_t h, int base, bq_t want);
    int n = h.size() - base;
    bit bad = (n != want.size());
    for (int i = 0; i < want.size() && !bad; i++)
      if (h[base+i] !== want[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s got [%s] want [%s]", name, fmt(h, base), fmt(want, 0));
    end
  endtask

  task automatic send(int who, bq_t b, bit with_last);
    logic [8:0] wd;
    for (int i = 0; i < b.size(); i++) begin
      wd = {with_last && (i == b.size() - 1), b[i]};
      if (who == 0) q0.push_back(wd);
      else          q1.push_back(wd);
    end
  endtask

  task automatic present();
    r0_val_i  = q0.size() > 0;
    r0_data_i = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    r0_last_i = (q0.size() > 0) ? q0[0][8] : 1'b0;
    r1_val_i  = q1.size() > 0;
    r1_data_i = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    r1_last_i = (q1.size() > 0) ? q1[0][8] : 1'b0;
  endtask

  task automatic compare_cycle();
    logic       v, l, took;
    logic [7:0] d;
    logic [13:0] e, a;
    if (!rst_ni) begin
      m_owner = -1; m_drop = 1'b0; m_quiet = 0; m_prev = 1;
    end
    v = (m_owner == 0) ? r0_val_i  : (m_owner == 1) ? r1_val_i  : 1'b0;
    l = (m_owner == 0) ? r0_last_i : (m_owner == 1) ? r1_last_i : 1'b0;
    d = (m_owner == 0) ? r0_data_i : (m_owner == 1) ? r1_data_i : 8'h00;
    e = '0;
    if (rst_ni && !srst_i && m_owner >= 0) begin
      e[2:1] = (m_owner == 0) ? 2'b01 : 2'b10;
      if (m_drop) begin
        if (m_owner == 0) e[13] = 1'b1; else e[12] = 1'b1;
      end else begin
        if (m_owner == 0) e[13] = uart_rdy_i; else e[12] = uart_rdy_i;
        e[11]   = v;
        e[10:3] = v ? d : 8'h00;
      end
      e[0] = !v && (m_quiet == TO - 1);
    end
    a = {r0_rdy_o, r1_rdy_o, uart_val_o, uart_data_o, grant_o, timeout_o};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t {r0rdy,r1rdy,val,data,gnt,to} got=%h want=%h", $time, a, e);
    end

    nx_owner = m_owner; nx_drop = m_drop; nx_quiet = m_quiet; nx_prev = m_prev;
    if (!rst_ni || srst_i) begin
      nx_owner = -1; nx_drop = 1'b0; nx_quiet = 0; nx_prev = 1;
    end else if (m_owner < 0) begin
      if (r0_val_i || r1_val_i) begin
        if (r0_val_i && r1_val_i) nx_owner = 1 - m_prev;
        else                      nx_owner = r1_val_i ? 1 : 0;
        nx_drop  = !uart_avail_i;
        nx_quiet = 0;
      end
    end else begin
      took = v && (m_drop || uart_rdy_i);
      if (took) begin
        nx_quiet = 0;
        if (l) begin nx_prev = m_owner; nx_owner = -1; end
      end else if (!v) begin
        if (m_quiet == TO - 1) begin nx_prev = m_owner; nx_owner = -1; end
        else nx_quiet = m_quiet + 1;
      end
      if (nx_owner >= 0 && !uart_avail_i) nx_drop = 1'b1;
    end

    gnt_h.push_back({6'b0, grant_o});
    to_h.push_back({7'b0, timeout_o});
    uv_h.push_back({7'b0, uart_val_o});
    r0r_h.push_back({7'b0, r0_rdy_o});
    r0a_h.push_back({7'b0, r0_val_i & r0_rdy_o});
    if (uart_val_o && uart_rdy_i) tx_log.push_back(uart_data_o);
    acc0 = r0_val_i & r0_rdy_o;
    acc1 = r1_val_i & r1_rdy_o;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge, then refresh requesters.
  task automatic tick();
    @(negedge clk_i);
    compare_cycle();
    @(posedge clk_i);
    if (!rst_ni) begin
      m_owner = -1; m_drop = 1'b0; m_quiet = 0; m_prev = 1;
    end else begin
      m_owner = nx_owner; m_drop = nx_drop; m_quiet = nx_quiet; m_prev = nx_prev;
    end
    #1;
    if (acc0 && q0.size() > 0) q0.delete(0);
    if (acc1 && q1.size() > 0) q1.delete(0);
    present();
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {18'b0, r0_rdy_o, r1_rdy_o, uart_val_o, uart_data_o, grant_o, timeout_o};
  endfunction

  initial begin
    bq_t w, b;
    int base, tbase;

    tick();
    chk_val("reset_outputs", outs(), 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk_val("idle_grant", {30'b0, grant_o}, 32'h0);

    // Simultaneous requests after reset: r0 first, one idle cycle, then r1
    base = gnt_h.size(); tbase = tx_log.size();
    b = '{8'h41, 8'h42, 8'h43}; send(0, b, 1'b1);
    b = '{8'h51, 8'h52};        send(1, b, 1'b1);
    present();
    repeat (8) tick();
    w = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00};
    chk_seq("rr_grants", gnt_h, base, w);
    w = '{8'h41, 8'h42, 8'h43, 8'h51, 8'h52};
    chk_seq("rr_bytes", tx_log, tbase, w);

    // r1 alone with UART backpressure
    base = gnt_h.size(); tbase = tx_log.size();
    b = '{8'h61, 8'h62, 8'h63}; send(1, b, 1'b1);
    present();
    w = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
    for (int i = 0; i < 7; i++) begin
      uart_rdy_i = w[i][0];
      tick();
    end
    uart_rdy_i = 1'b1;
    w = '{8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00};
    chk_seq("stall_grants", gnt_h, base, w);
    w = '{8'h61, 8'h62, 8'h63};
    chk_seq("stall_bytes", tx_log, tbase, w);
    chk_val("stall_r0_rdy", sum(r0r_h, base), 0);

    // No host: r0 packet drained, never transmitted
    base = gnt_h.size();
    uart_avail_i = 1'b0;
    b = '{8'h71, 8'h72}; send(0, b, 1'b1);
    present();
    repeat (4) tick();
    uart_avail_i = 1'b1;
    w = '{8'h00, 8'h01, 8'h01, 8'h00};
    chk_seq("drop_grants", gnt_h, base, w);
    chk_val("drop_uart_val", sum(uv_h, base), 0);
    chk_val("drop_r0_accepts", sum(r0a_h, base), 2);

    // Owner goes quiet mid-packet: revoked after TO idle cycles, waiting r1 served
    base = gnt_h.size(); tbase = tx_log.size();
    b = '{8'h81}; send(0, b, 1'b0);
    present();
    tick(); tick();
    b = '{8'h91}; send(1, b, 1'b1);
    present();
    repeat (7) tick();
    w = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00};
    chk_seq("timeout_grants", gnt_h, base, w);
    w = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    chk_seq("timeout_pulse", to_h, base, w);
    w = '{8'h81, 8'h91};
    chk_seq("timeout_bytes", tx_log, tbase, w);

    // Async reset in the middle of an r1 packet
    b = '{8'ha1, 8'ha2, 8'ha3, 8'ha4}; send(1, b, 1'b1);
    present();
    tick(); tick();
    chk_val("pre_rst_grant", {30'b0, grant_o}, 32'h2);
    rst_ni = 1'b0;
    #1;
    chk_val("async_rst_zero", outs(), 32'h0);
    q0.delete(); q1.delete();
    present();
    tick(); tick();
    rst_ni = 1'b1;
    base = gnt_h.size(); tbase = tx_log.size();
    b = '{8'hb1}; send(0, b, 1'b1);
    b = '{8'hc1}; send(1, b, 1'b1);
    present();
    repeat (5) tick();
    w = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
    chk_seq("post_rst_grants", gnt_h, base, w);
    w = '{8'hb1, 8'hc1};
    chk_seq("post_rst_bytes", tx_log, tbase, w);

    // Host leaves after the first of four bytes
    base = gnt_h.size(); tbase = tx_log.size();
    b = '{8'hd1, 8'hd2, 8'hd3, 8'hd4}; send(0, b, 1'b1);
    present();
    tick();
    uart_avail_i = 1'b0;
    repeat (5) tick();
    uart_avail_i = 1'b1;
    w = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    chk_seq("avail_fall_grants", gnt_h, base, w);
    w = '{8'hd1};
    chk_seq("avail_fall_bytes", tx_log, tbase, w);
    chk_val("avail_fall_accepts", sum(r0a_h, base), 4);

    // Soft reset mid-packet
    b = '{8'he1, 8'he2, 8'he3}; send(1, b, 1'b1);
    present();
    tick(); tick();
    srst_i = 1'b1;
    #1;
    chk_val("srst_zero", outs(), 32'h0);
    tick();
    srst_i = 1'b0;
    q0.delete(); q1.delete();
    present();
    base = gnt_h.size(); tbase = tx_log.size();
    b = '{8'hf1}; send(0, b, 1'b1);
    b = '{8'hf2}; send(1, b, 1'b1);
    present();
    repeat (5) tick();
    w = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
    chk_seq("post_srst_grants", gnt_h, base, w);
    w = '{8'hf1, 8'hf2};
    chk_seq("post_srst_bytes", tx_log, tbase, w);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_arb.md
UART_ARB -- requirements
Module: uart_arb

Interface
REQ-001 Parameter TIMEOUT, default 1024: idle cycles inside a granted packet before the grant is revoked; legal range 2..65535.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 srst_i  in  1  synchronous soft reset, active-high; same effect as rst_ni.
REQ-005 r0_val_i / r0_data_i / r0_last_i  in  1/8/1  requester 0 (stdout path) byte valid, byte, end-of-packet marker.
REQ-006 r0_rdy_o  out  1  requester 0 byte accepted when r0_val_i & r0_rdy_o.
REQ-007 r1_val_i / r1_data_i / r1_last_i  in  1/8/1  requester 1 (debug dump) byte valid, byte, end-of-packet marker.
REQ-008 r1_rdy_o  out  1  requester 1 byte accepted when r1_val_i & r1_rdy_o.
REQ-009 uart_val_o / uart_data_o  out  1/8  byte to UART transmitter.
REQ-010 uart_rdy_i  in  1  UART accepts byte when uart_val_o & uart_rdy_i.
REQ-011 uart_avail_i  in  1  host terminal present (DTR asserted).
REQ-012 grant_o  out  2  one-hot current owner ({r1,r0}); 2'b00 when none.
REQ-013 timeout_o  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 States: IDLE, GNT0, GNT1, DROP0, DROP1; register last_q records most recently granted requester.
REQ-015 IDLE: all rdy_o=0, uart_val_o=0; if uart_avail_i=1 and any rN_val_i=1, next state GNTn; one-cycle grant latency.
REQ-016 Simultaneous requests in IDLE: grant requester != last_q (round-robin); single request: grant that requester.
REQ-017 IDLE with uart_avail_i=0 and any rN_val_i=1: next state DROPn, same round-robin choice.
REQ-018 GNTn: uart_val_o=rN_val_i, uart_data_o=rN_data_i, rN_rdy_o=uart_rdy_i, other rdy_o=0; zero-cycle pass-through.
REQ-019 GNTn: accepted byte with rN_last_i=1 -> IDLE next cycle, last_q<=n; no back-to-back regrant without one IDLE cycle.
REQ-020 GNTn: uart_avail_i falls -> DROPn next cycle; packet continues being consumed, not transmitted.
REQ-021 DROPn: rN_rdy_o=1, uart_val_o=0; bytes discarded; accepted byte with last=1 -> IDLE, last_q<=n.
REQ-022 16-bit idle counter clears on every accepted byte and on grant entry; increments each GNTn/DROPn cycle with rN_val_i=0.
REQ-023 Counter reaching TIMEOUT-1 -> IDLE next cycle, last_q<=n, timeout_o=1 for that one cycle.
REQ-024 uart_data_o=8'h00 whenever uart_val_o=0.
REQ-025 grant_o reflects GNTn or DROPn owner; 2'b00 in IDLE.
REQ-026 Owner changing rN_data_i while rN_val_i=1 and not accepted: undefined upstream behaviour; block passes it through unchanged.

Reset
REQ-027 rst_ni=0 (async) or srst_i=1 (next edge): state IDLE, last_q=1, counter=0.
REQ-028 During reset: all rdy_o=0, uart_val_o=0, uart_data_o=8'h00, grant_o=2'b00, timeout_o=0.
REQ-029 Reset mid-packet aborts the packet; no partial-packet resume after reset.

Verification
REQ-030 After reset, avail=1, both val=1 same cycle -> grant_o=01 next cycle; r0 3-byte packet 41,42,43(last) emitted in order; IDLE 1 cycle; then grant_o=10.
REQ-031 r1 alone, uart_rdy_i toggled 1,0,1 -> bytes stall on rdy=0, no drop/dup, r0_rdy_o=0 throughout.
REQ-032 avail=0, r0 sends 2-byte packet -> grant_o=01, r0_rdy_o=1, uart_val_o never 1, returns IDLE after last.
REQ-033 TIMEOUT=4, r0 sends one non-last byte then val=0 -> timeout_o pulses once after 4 idle cycles, grant_o=00 next, pending r1 granted.
REQ-034 rst_ni asserted mid-packet in GNT1 -> outputs zero immediately; after release both requesting -> r0 granted first.
REQ-035 uart_avail_i falls after byte 1 of 4 in GNT0 -> bytes 2-4 consumed with uart_val_o=0, state IDLE after byte 4.
